// File: rtl/uart_pkg.sv
// uart_pkg: shared UART-side types and constants
package uart_pkg;
    typedef enum logic [2:0] {IDLE, LOAD_HDR, WAIT_HDR, LOAD_DATA, WAIT_DATA} tx_arb_state_t;
    localparam logic [7:0] HDR_TAG = 8'hA0;
    localparam int MAX_REQ = 16;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after the pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_Req,
    input  logic [$clog2(N)-1:0] i_Ptr,
    output logic [$clog2(N)-1:0] o_Grant_Idx,
    output logic                 o_Any
);
    localparam int IW = $clog2(N);
    always_comb begin
        o_Grant_Idx = '0;
        o_Any = |i_Req;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = int'(i_Ptr) + k;
            j = (j >= N) ? j - N : j;
            if (i_Req[IW'(j)]) o_Grant_Idx = IW'(j);
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among byte requesters, with optional tag byte
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 87,
    parameter bit HEADER_EN    = 1'b1,
    parameter int TIMEOUT_CLKS = 12 * CLKS_PER_BIT
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [NUM_REQ-1:0]   i_Req_Valid,
    input  logic [NUM_REQ*8-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]   o_Req_Ready,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic                 o_Busy,
    output logic                 o_Timeout
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ out of range");
    end
    tx_arb_state_t state;
    logic [IW-1:0] ptr, idx, win, ptr_next;
    logic [7:0] data;
    logic [TW-1:0] timer;
    logic any;
    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_Req(i_Req_Valid),
        .i_Ptr(ptr),
        .o_Grant_Idx(win),
        .o_Any(any)
    );
    assign ptr_next = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    // The first DV is registered on the grant edge so Ready and DV share a cycle.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= IDLE;
            ptr         <= '0;
            idx         <= '0;
            data        <= '0;
            timer       <= '0;
            o_Req_Ready <= '0;
            o_Grant     <= '0;
            o_Tx_DV     <= 1'b0;
            o_Tx_Byte   <= '0;
            o_Busy      <= 1'b0;
            o_Timeout   <= 1'b0;
        end else begin
            o_Req_Ready <= '0;
            o_Tx_DV     <= 1'b0;
            o_Timeout   <= 1'b0;
            case (state)
                IDLE: if (any && !i_Tx_Active) begin
                    idx         <= win;
                    data        <= i_Req_Byte[8*win +: 8];
                    o_Req_Ready <= NUM_REQ'(1) << win;
                    o_Grant     <= NUM_REQ'(1) << win;
                    o_Busy      <= 1'b1;
                    o_Tx_DV     <= 1'b1;
                    o_Tx_Byte   <= HEADER_EN ? (HDR_TAG | 8'(win)) : i_Req_Byte[8*win +: 8];
                    state       <= HEADER_EN ? LOAD_HDR : LOAD_DATA;
                end
                LOAD_HDR: begin
                    state <= WAIT_HDR;
                    timer <= '0;
                end
                LOAD_DATA: begin
                    state <= WAIT_DATA;
                    timer <= '0;
                end
                WAIT_HDR, WAIT_DATA: begin
                    timer <= timer + 1'b1;
                    if (i_Tx_Done && state == WAIT_HDR) begin
                        state     <= LOAD_DATA;
                        o_Tx_DV   <= 1'b1;
                        o_Tx_Byte <= data;
                    end else if (i_Tx_Done || timer == TW'(TIMEOUT_CLKS - 1)) begin
                        state     <= IDLE;
                        o_Grant   <= '0;
                        o_Busy    <= 1'b0;
                        ptr       <= ptr_next;
                        o_Timeout <= !i_Tx_Done;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a behavioural uart_tx timing model
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int CPB = 87;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #50 clk = ~clk;

    logic [3:0] vld = '0, rdy, grant0;
    logic [31:0] bytes = '0;
    logic dv0, busy0, to0, done_in, active_in;
    logic [7:0] txb0;
    logic [3:0] vld1 = '0, rdy1, grant1;
    logic [31:0] bytes1 = '0;
    logic dv1, busy1, to1;
    logic active1 = 1'b0, done1 = 1'b0;
    logic [7:0] txb1;

    logic model_en = 1'b1, force_active = 1'b0;
    logic m_active = 1'b0, m_done = 1'b0;
    int m_cnt = 0;
    assign active_in = m_active | force_active;
    assign done_in = m_done;

    int vectors = 0, miscompares = 0, done_cnt = 0, dv1_cnt = 0;
    logic [7:0] exp0[$], exp1[$];
    int order[$];

    uart_tx_arbiter #(.NUM_REQ(4), .CLKS_PER_BIT(CPB), .HEADER_EN(1'b1)) dut0 (
        .i_Clock(clk), .i_Reset(rst), .i_Req_Valid(vld), .i_Req_Byte(bytes),
        .o_Req_Ready(rdy), .o_Grant(grant0), .o_Tx_DV(dv0), .o_Tx_Byte(txb0),
        .i_Tx_Active(active_in), .i_Tx_Done(done_in), .o_Busy(busy0), .o_Timeout(to0)
    );
    uart_tx_arbiter #(.NUM_REQ(4), .CLKS_PER_BIT(CPB), .HEADER_EN(1'b0)) dut1 (
        .i_Clock(clk), .i_Reset(rst), .i_Req_Valid(vld1), .i_Req_Byte(bytes1),
        .o_Req_Ready(rdy1), .o_Grant(grant1), .o_Tx_DV(dv1), .o_Tx_Byte(txb1),
        .i_Tx_Active(active1), .i_Tx_Done(done1), .o_Busy(busy1), .o_Timeout(to1)
    );

    // uart_tx timing: busy for 10 bit times after DV, then a one-cycle Done
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (model_en && dv0) begin
            m_active <= 1'b1;
            m_cnt <= 10 * CPB;
        end else if (m_active) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_active <= 1'b0;
                m_done <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s wait bound expired", tag);
    endtask

    always @(negedge clk) begin
        if (dv0) begin
            if (exp0.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL sb0_extra observed=%0h expected=none", txb0);
            end else chk("sb0_byte", 32'(txb0), 32'(exp0.pop_front()));
        end
        if (dv1) begin
            dv1_cnt++;
            if (exp1.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL sb1_extra observed=%0h expected=none", txb1);
            end else chk("sb1_byte", 32'(txb1), 32'(exp1.pop_front()));
        end
        if (m_done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++)
            if (rdy[n]) begin
                vld[n] = 1'b0;
                order.push_back(n);
            end
    endtask

    task automatic drain(input string tag, input int max);
        int c;
        c = 0;
        do begin
            step();
            c++;
        end while ((vld != 0 || busy0) && c < max);
        if (c >= max) bound_fail(tag);
    endtask

    task automatic reset_dut();
        vld = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic int packed_order();
        int v;
        v = 1;
        foreach (order[i]) v = (v << 4) | order[i];
        return v;
    endfunction

    task automatic req(input int n, input logic [7:0] b);
        bytes[8*n +: 8] = b;
        vld[n] = 1'b1;
        exp0.push_back(8'hA0 | 8'(n));
        exp0.push_back(b);
    endtask

    initial begin
        int c;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {rdy, grant0, dv0, txb0, busy0, to0}, 0);
        chk("rst_outs1", {rdy1, grant1, dv1, txb1, busy1, to1}, 0);
        rst = 1'b0;
        step();

        // single requester with header
        done_cnt = 0;
        order.delete();
        req(1, 8'h3F);
        step();
        chk("t1_ready", 32'(rdy), 4'b0010);
        chk("t1_dv", 32'(dv0), 1);
        chk("t1_hdr", 32'(txb0), 8'hA1);
        chk("t1_grant", 32'(grant0), 4'b0010);
        drain("t1_drain", 4000);
        chk("t1_order", packed_order(), 32'h11);
        chk("t1_dones", done_cnt, 2);
        chk("t1_idle", {busy0, grant0}, 0);

        // round-robin from reset, req0 re-asserted mid-run
        reset_dut();
        order.delete();
        for (int n = 0; n < 4; n++) req(n, 8'h10 + 8'(n));
        c = 0;
        while (order.size() < 2 && c < 4000) begin
            step();
            c++;
        end
        if (c >= 4000) bound_fail("t2_mid");
        req(0, 8'h55);
        drain("t2_drain", 12000);
        chk("t2_order", packed_order(), 32'h101230);

        // pointer wrap: pointer at 3, requests on 0 and 2
        reset_dut();
        req(2, 8'h22);
        drain("t3_prep", 4000);
        order.delete();
        req(0, 8'h30);
        req(2, 8'h32);
        drain("t3_drain", 8000);
        chk("t3_order", packed_order(), 32'h102);

        // watchdog abort with Done never arriving
        model_en = 1'b0;
        order.delete();
        bytes[15:8] = 8'h99;
        vld[1] = 1'b1;
        exp0.push_back(8'hA1);
        step();
        chk("t4_dv", 32'(dv0), 1);
        c = 0;
        do begin
            step();
            c++;
        end while (!to0 && c < 2000);
        chk("t4_latency", c, 1045);
        chk("t4_idle", {busy0, grant0}, 0);
        step();
        chk("t4_pulse", 32'(to0), 0);
        force_active = 1'b1;
        order.delete();
        vld[3] = 1'b1;
        repeat (20) step();
        chk("t4_blocked_busy", 32'(busy0), 0);
        chk("t4_blocked_ready", order.size(), 0);
        vld = '0;
        force_active = 1'b0;
        model_en = 1'b1;

        // reset during WAIT_DATA, then a late Done
        reset_dut();
        req(2, 8'h77);
        c = 0;
        do begin
            step();
            c++;
        end while (!(dv0 && txb0 == 8'h77) && c < 3000);
        if (c >= 3000) bound_fail("t5_data");
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("t5_rst_outs", {rdy, grant0, dv0, txb0, busy0, to0}, 0);
        rst = 1'b0;
        c = 0;
        while (!m_done && c < 2000) begin
            step();
            c++;
        end
        if (c >= 2000) bound_fail("t5_late_done");
        step();
        chk("t5_late_idle", {busy0, grant0, dv0}, 0);
        order.delete();
        req(1, 8'h41);
        req(3, 8'h43);
        drain("t5_drain", 8000);
        chk("t5_ptr_reset_order", packed_order(), 32'h113);

        // data-only instance
        bytes1[23:16] = 8'hAB;
        vld1[2] = 1'b1;
        exp1.push_back(8'hAB);
        @(posedge clk);
        #1;
        chk("t6_ready", 32'(rdy1), 4'b0100);
        chk("t6_dv", 32'(dv1), 1);
        chk("t6_byte", 32'(txb1), 8'hAB);
        vld1 = '0;
        step();
        chk("t6_dv_pulse", 32'(dv1), 0);
        repeat (3) step();
        done1 = 1'b1;
        step();
        done1 = 1'b0;
        step();
        chk("t6_idle", {busy1, grant1}, 0);
        chk("t6_dv_count", dv1_cnt, 1);

        chk("sb0_empty", exp0.size(), 0);
        chk("sb1_empty", exp1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
